// File: rtl/fft_pkg.sv
// Shared constants for the FFT butterfly blocks: default widths, twiddle unity and
// saturation limits.
package fft_pkg;
  localparam int DEF_NBITS   = 16;
  localparam int DEF_TW_FRAC = 14;
  localparam int TW_ONE      = 1 << DEF_TW_FRAC;
  localparam int SAT_MAX     = (1 << (DEF_NBITS - 1)) - 1;
  localparam int SAT_MIN     = -(1 << (DEF_NBITS - 1));
endpackage

// File: rtl/bfly_round_sat.sv
// Round-half-up arithmetic right shift by SHIFT, then saturate to a signed NBITS result.
// sat reports that the clamp was applied.
module bfly_round_sat
  import fft_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int SHIFT = 1,
  parameter int NBITS = DEF_NBITS
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [NBITS-1:0] dout,
  output logic                    sat
);
  localparam int RW = IN_W + 1;
  localparam logic signed [RW-1:0] ONE  = 1;
  localparam logic signed [RW-1:0] MAXV = (ONE <<< (NBITS - 1)) - ONE;
  localparam logic signed [RW-1:0] MINV = -(ONE <<< (NBITS - 1));

  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] shifted;

  // One guard bit keeps the rounding constant from overflowing the input range
  assign ext = RW'(din);

  generate
    if (SHIFT > 0) begin : g_round
      logic signed [RW-1:0] rounded;
      assign rounded = ext + (ONE <<< (SHIFT - 1));
      assign shifted = rounded >>> SHIFT;
    end else begin : g_pass
      assign shifted = ext;
    end
  endgenerate

  always_comb begin
    sat  = 1'b0;
    dout = shifted[NBITS-1:0];
    if (shifted > MAXV) begin
      sat  = 1'b1;
      dout = MAXV[NBITS-1:0];
    end else if (shifted < MINV) begin
      sat  = 1'b1;
      dout = MINV[NBITS-1:0];
    end
  end
endmodule

// File: rtl/ifft_butterfly_dif.sv
// Three-stage DIF inverse butterfly: X = (A+B)*s, Y = (A-B)*conj(W)*s with valid/ready flow.
// Define IFFT_BFLY_SCALE_EN for s = 1/2 per butterfly; otherwise s = 1.
module ifft_butterfly_dif
  import fft_pkg::*;
#(
  parameter int NBITS   = DEF_NBITS,
  parameter int TW_FRAC = DEF_TW_FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [NBITS-1:0] Ar,
  input  logic signed [NBITS-1:0] Ai,
  input  logic signed [NBITS-1:0] Br,
  input  logic signed [NBITS-1:0] Bi,
  input  logic signed [NBITS-1:0] Wr,
  input  logic signed [NBITS-1:0] Wi,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [NBITS-1:0] Xr,
  output logic signed [NBITS-1:0] Xi,
  output logic signed [NBITS-1:0] Yr,
  output logic signed [NBITS-1:0] Yi,
  output logic                    sat_flag,
  input  logic                    clear_sat
);
`ifdef IFFT_BFLY_SCALE_EN
  localparam int SCALE = 1;
`else
  localparam int SCALE = 0;
`endif
  localparam int DW = NBITS + 1;
  localparam int PW = 2 * NBITS + 1;
  localparam int SW = 2 * NBITS + 2;
  localparam int K  = TW_FRAC + SCALE;

  logic advance;
  logic v1, v2;
  logic signed [DW-1:0]    s1_sr, s1_si, s1_dr, s1_di;
  logic signed [NBITS-1:0] s1_wr, s1_wi;
  logic signed [DW-1:0]    s2_sr, s2_si;
  logic signed [PW-1:0]    s2_prr, s2_pii, s2_pir, s2_pri;
  logic signed [SW-1:0]    yr_full, yi_full;
  logic signed [NBITS-1:0] xr_n, xi_n, yr_n, yi_n;
  logic [3:0]              sat_c;

  // The whole pipeline freezes while a result sits unaccepted at the output
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (advance) begin
      v1 <= in_valid;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_sr <= DW'(Ar) + DW'(Br);
      s1_si <= DW'(Ai) + DW'(Bi);
      s1_dr <= DW'(Ar) - DW'(Br);
      s1_di <= DW'(Ai) - DW'(Bi);
      s1_wr <= Wr;
      s1_wi <= Wi;
    end
    if (advance && v1) begin
      s2_sr  <= s1_sr;
      s2_si  <= s1_si;
      s2_prr <= PW'(s1_dr) * PW'(s1_wr);
      s2_pii <= PW'(s1_di) * PW'(s1_wi);
      s2_pir <= PW'(s1_di) * PW'(s1_wr);
      s2_pri <= PW'(s1_dr) * PW'(s1_wi);
    end
  end

  // Multiplying by conj(W) flips the sign of the Wi cross terms
  assign yr_full = SW'(s2_prr) + SW'(s2_pii);
  assign yi_full = SW'(s2_pir) - SW'(s2_pri);

  bfly_round_sat #(.IN_W(DW), .SHIFT(SCALE), .NBITS(NBITS)) u_rs_xr (.din(s2_sr),   .dout(xr_n), .sat(sat_c[0]));
  bfly_round_sat #(.IN_W(DW), .SHIFT(SCALE), .NBITS(NBITS)) u_rs_xi (.din(s2_si),   .dout(xi_n), .sat(sat_c[1]));
  bfly_round_sat #(.IN_W(SW), .SHIFT(K),     .NBITS(NBITS)) u_rs_yr (.din(yr_full), .dout(yr_n), .sat(sat_c[2]));
  bfly_round_sat #(.IN_W(SW), .SHIFT(K),     .NBITS(NBITS)) u_rs_yi (.din(yi_full), .dout(yi_n), .sat(sat_c[3]));

  // A saturation being loaded this edge outranks a simultaneous clear request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Xr        <= '0;
      Xi        <= '0;
      Yr        <= '0;
      Yi        <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (advance) begin
        out_valid <= v2;
        if (v2) begin
          Xr <= xr_n;
          Xi <= xi_n;
          Yr <= yr_n;
          Yi <= yi_n;
        end
      end
      sat_flag <= (advance && v2 && (|sat_c)) || (sat_flag && !clear_sat);
    end
  end
endmodule
